// File: rtl/y86_prog_loader.sv
// y86_prog_loader
// Loads a Y86-64 program from a valid/ready byte stream into a byte-wide
// instruction memory. Once the final byte is in, it releases the processor
// and serves its 10-byte little-endian fetch window. The first non-AOK
// status freezes the block in a done state with that status latched.

module y86_prog_loader #(
    parameter int MEM_BYTES = 1024,
    parameter int ADDR_W    = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld_valid,
    input  logic [7:0]        ld_data,
    input  logic              ld_last,
    output logic              ld_ready,
    input  logic [63:0]       f_PC,
    output logic [79:0]       f_instr,
    output logic              imem_error,
    input  logic [1:0]        stat,
    output logic              cpu_run,
    output logic              done,
    output logic [1:0]        final_stat,
    output logic [ADDR_W:0]   load_count,
    output logic              load_err
);

    typedef enum logic [1:0] {
        LOAD,
        RUN,
        DONE
    } state_t;

    // Address of the last memory byte. Accepting a byte here without the
    // last flag means the program does not fit in memory.
    localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(MEM_BYTES - 1);
    // Highest fetch address whose full 10-byte window is still inside memory.
    localparam logic [63:0]       LAST_WINDOW = 64'(MEM_BYTES - 10);

    logic [7:0]        mem [MEM_BYTES];

    state_t            state_q;
    logic [ADDR_W-1:0] wptr_q;
    logic [ADDR_W-1:0] wptr_d;
    logic [ADDR_W:0]   loadCount_q;
    logic [ADDR_W:0]   loadCount_d;
    logic              loadErr_q;
    logic [1:0]        finalStat_q;
    logic              cpuRun_q;
    logic              done_q;
    logic              ldReady_q;
    logic              accept;

    // ld_ready is only ever high while loading, so this also implies LOAD.
    assign accept      = ld_valid & ldReady_q;
    assign wptr_d      = wptr_q + 1'b1;
    assign loadCount_d = loadCount_q + 1'b1;

    // Program memory write port. Memory contents deliberately survive reset,
    // so a partially loaded program can still be seen after a restart.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wptr_q] <= ld_data;
        end
    end

    // Control FSM with all status outputs registered alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= LOAD;
            wptr_q      <= '0;
            loadCount_q <= '0;
            loadErr_q   <= 1'b0;
            finalStat_q <= 2'd0;
            cpuRun_q    <= 1'b0;
            done_q      <= 1'b0;
            ldReady_q   <= 1'b1;
        end else begin
            case (state_q)
                LOAD: begin
                    if (accept) begin
                        wptr_q      <= wptr_d;
                        loadCount_q <= loadCount_d;
                        if (ld_last) begin
                            state_q   <= RUN;
                            ldReady_q <= 1'b0;
                            cpuRun_q  <= 1'b1;
                        end else if (wptr_q == LAST_ADDR) begin
                            state_q     <= DONE;
                            ldReady_q   <= 1'b0;
                            loadErr_q   <= 1'b1;
                            done_q      <= 1'b1;
                            finalStat_q <= 2'd0;
                        end
                    end
                end
                RUN: begin
                    if (stat != 2'd0) begin
                        state_q     <= DONE;
                        finalStat_q <= stat;
                        cpuRun_q    <= 1'b0;
                        done_q      <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= DONE;
                end
                default: begin
                    state_q <= LOAD;
                end
            endcase
        end
    end

    // Fetch window: ten independent byte lanes. The address sum is kept at
    // 65 bits so a window starting near the top of the 64-bit space cannot
    // wrap back onto low memory; anything outside memory reads as zero.
    for (genvar i = 0; i < 10; i++) begin : g_lane
        logic [64:0] laneAddr;
        assign laneAddr = {1'b0, f_PC} + 65'(i);
        assign f_instr[8*i +: 8] = (laneAddr[64:ADDR_W] == '0)
                                   ? mem[laneAddr[ADDR_W-1:0]] : 8'h00;
    end

    assign imem_error = (f_PC > LAST_WINDOW);

    assign ld_ready   = ldReady_q;
    assign cpu_run    = cpuRun_q;
    assign done       = done_q;
    assign final_stat = finalStat_q;
    assign load_count = loadCount_q;
    assign load_err   = loadErr_q;

endmodule

// File: tb/tb_y86_prog_loader.sv
// tb_y86_prog_loader
// Directed bench for the program loader: load, reset mid-load, halt
// latching, overflow of memory and the fetch window boundaries.

module tb_y86_prog_loader;

    localparam int MEM_BYTES = 1024;
    localparam int ADDR_W    = 10;

    logic              clk = 1'b0;
    logic              rst;
    logic              ld_valid;
    logic [7:0]        ld_data;
    logic              ld_last;
    logic              ld_ready;
    logic [63:0]       f_PC;
    logic [79:0]       f_instr;
    logic              imem_error;
    logic [1:0]        stat;
    logic              cpu_run;
    logic              done;
    logic [1:0]        final_stat;
    logic [ADDR_W:0]   load_count;
    logic              load_err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic [63:0] pc;
        logic        expErr;
        logic [79:0] expInstr;
    } fetchVec_t;

    fetchVec_t fetchTab [7];

    y86_prog_loader #(.MEM_BYTES(MEM_BYTES), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .ld_valid   (ld_valid),
        .ld_data    (ld_data),
        .ld_last    (ld_last),
        .ld_ready   (ld_ready),
        .f_PC       (f_PC),
        .f_instr    (f_instr),
        .imem_error (imem_error),
        .stat       (stat),
        .cpu_run    (cpu_run),
        .done       (done),
        .final_stat (final_stat),
        .load_count (load_count),
        .load_err   (load_err)
    );

    // 10 ns clock.
    always #5 clk = ~clk;

    // Hard stop in case anything stalls far beyond the expected run length.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // Advance one clock and settle just past the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one loader beat for a single clock, then drop valid.
    task automatic applyStimulus(input logic valid, input logic [7:0] data,
                                 input logic last);
        ld_valid = valid;
        ld_data  = data;
        ld_last  = last;
        tick();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    task automatic checkOutput(input string name, input logic [79:0] actual,
                               input logic [79:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic doReset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        logic [7:0] prog [11];
        int         runSeen;

        prog = '{8'h30, 8'hF2, 8'h05, 8'h00, 8'h00, 8'h00,
                 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

        // After the overflow load, mem[a] = a[7:0] ^ 8'h5A.
        fetchTab[0] = '{"fetch_pc0",    64'd0,    1'b0, 80'h5352_5D5C_5F5E_5958_5B5A};
        fetchTab[1] = '{"fetch_pc1014", 64'd1014, 1'b0, 80'hA5A4_A7A6_A1A0_A3A2_ADAC};
        fetchTab[2] = '{"fetch_pc1015", 64'd1015, 1'b1, 80'h00A5_A4A7_A6A1_A0A3_A2AD};
        fetchTab[3] = '{"fetch_pc1023", 64'd1023, 1'b1, 80'h0000_0000_0000_0000_00A5};
        fetchTab[4] = '{"fetch_pc1024", 64'd1024, 1'b1, 80'h0};
        fetchTab[5] = '{"fetch_pc_max", 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 80'h0};
        fetchTab[6] = '{"fetch_pc_hi",  64'h1_0000_0000, 1'b1, 80'h0};

        rst      = 1'b1;
        ld_valid = 1'b0;
        ld_data  = 8'h00;
        ld_last  = 1'b0;
        f_PC     = 64'd0;
        stat     = 2'd0;
        doReset();

        checkOutput("rst_ld_ready",   80'(ld_ready),   80'd1);
        checkOutput("rst_cpu_run",    80'(cpu_run),    80'd0);
        checkOutput("rst_done",       80'(done),       80'd0);
        checkOutput("rst_load_err",   80'(load_err),   80'd0);
        checkOutput("rst_final_stat", 80'(final_stat), 80'd0);
        checkOutput("rst_load_count", 80'(load_count), 80'd0);

        // Program load with a gap in ld_valid half way through.
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, prog[i], 1'b0);
            if (i == 4) applyStimulus(1'b0, 8'hEE, 1'b0);
        end
        checkOutput("pre_last_cpu_run", 80'(cpu_run),    80'd0);
        checkOutput("pre_last_count",   80'(load_count), 80'd10);
        applyStimulus(1'b1, prog[10], 1'b1);
        checkOutput("load_count_11",  80'(load_count), 80'd11);
        checkOutput("run_cpu_run",    80'(cpu_run),    80'd1);
        checkOutput("run_ld_ready",   80'(ld_ready),   80'd0);
        f_PC = 64'd0;
        #1;
        checkOutput("prog_f_instr_lo", 80'(f_instr[15:0]), 80'hF230);
        checkOutput("prog_f_instr",    f_instr, 80'h0000_0000_0000_0005_F230);
        checkOutput("prog_imem_err",   80'(imem_error), 80'd0);

        // Reset part way into a new load; stale bytes remain in memory.
        doReset();
        applyStimulus(1'b1, 8'hAA, 1'b0);
        applyStimulus(1'b1, 8'hBB, 1'b0);
        applyStimulus(1'b1, 8'hCC, 1'b0);
        applyStimulus(1'b1, 8'hDD, 1'b0);
        doReset();
        checkOutput("midrst_count", 80'(load_count), 80'd0);
        applyStimulus(1'b1, 8'h11, 1'b0);
        applyStimulus(1'b1, 8'h22, 1'b1);
        checkOutput("reload_count",   80'(load_count), 80'd2);
        checkOutput("reload_cpu_run", 80'(cpu_run),    80'd1);
        checkOutput("reload_done",    80'(done),       80'd0);
        checkOutput("reload_f_instr", f_instr, 80'h0000_0000_0000_DDCC_2211);

        // Loader traffic during RUN is ignored.
        applyStimulus(1'b1, 8'h77, 1'b0);
        checkOutput("run_ignore_count", 80'(load_count), 80'd2);

        // One-cycle HLT status, then back to AOK: result must latch.
        stat = 2'd1;
        tick();
        stat = 2'd0;
        checkOutput("hlt_done",       80'(done),       80'd1);
        checkOutput("hlt_cpu_run",    80'(cpu_run),    80'd0);
        checkOutput("hlt_final_stat", 80'(final_stat), 80'd1);
        stat = 2'd3;
        tick();
        tick();
        stat = 2'd0;
        applyStimulus(1'b1, 8'h99, 1'b1);
        applyStimulus(1'b1, 8'h98, 1'b0);
        checkOutput("hold_done",       80'(done),       80'd1);
        checkOutput("hold_cpu_run",    80'(cpu_run),    80'd0);
        checkOutput("hold_final_stat", 80'(final_stat), 80'd1);
        checkOutput("hold_count",      80'(load_count), 80'd2);
        checkOutput("hold_ld_ready",   80'(ld_ready),   80'd0);

        // Overflow: stream the whole memory with ld_valid held and no last.
        doReset();
        runSeen  = 0;
        ld_valid = 1'b1;
        ld_last  = 1'b0;
        for (int i = 0; i < MEM_BYTES; i++) begin
            ld_data = 8'(i) ^ 8'h5A;
            tick();
            if (cpu_run) runSeen++;
            if (i == MEM_BYTES - 2) begin
                checkOutput("ovf_pre_done",  80'(done),       80'd0);
                checkOutput("ovf_pre_count", 80'(load_count), 80'd1023);
            end
        end
        ld_valid = 1'b0;
        tick();
        checkOutput("ovf_load_err",   80'(load_err),   80'd1);
        checkOutput("ovf_done",       80'(done),       80'd1);
        checkOutput("ovf_cpu_never",  80'(runSeen),    80'd0);
        checkOutput("ovf_cpu_run",    80'(cpu_run),    80'd0);
        checkOutput("ovf_count",      80'(load_count), 80'd1024);
        checkOutput("ovf_final_stat", 80'(final_stat), 80'd0);

        // Fetch window boundaries against the known memory image.
        for (int i = 0; i < 7; i++) begin
            f_PC = fetchTab[i].pc;
            #1;
            checkOutput({fetchTab[i].name, "_err"}, 80'(imem_error),
                        80'(fetchTab[i].expErr));
            checkOutput(fetchTab[i].name, f_instr, fetchTab[i].expInstr);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/y86_prog_loader.md
# y86_prog_loader

Program loader and instruction-memory responder for the pipelined Y86-64 processor. A byte stream with a valid/ready handshake fills a byte-addressed instruction memory. The block then releases the processor and serves its fetch port with 10 little-endian bytes at `f_PC`. It watches the processor's `stat` and freezes into a done state on the first non-AOK status, which gives the bench a single completion flag.

## Interface
Parameters:
- `MEM_BYTES`, 1024: instruction memory size in bytes; must be a power of two and at least 16.
- `ADDR_W`, 10: write-pointer width; equals log2(`MEM_BYTES`).

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `ld_valid`  in  1  loader byte valid.
- `ld_data`  in  8  loader byte.
- `ld_last`  in  1  marks the final byte of the program; qualified by `ld_valid`.
- `ld_ready`  out  1  block accepts a byte this cycle.
- `f_PC`  in  64  fetch address from the processor.
- `f_instr`  out  80  bytes `f_PC`..`f_PC`+9; byte `f_PC` sits in bits [7:0].
- `imem_error`  out  1  fetch window exceeds memory, i.e. `f_PC` > `MEM_BYTES`-10, compared on the full 64 bits.
- `stat`  in  2  processor status; 0 means AOK.
- `cpu_run`  out  1  processor enable.
- `done`  out  1  run finished or load failed.
- `final_stat`  out  2  `stat` value latched on completion.
- `load_count`  out  ADDR_W+1  number of bytes accepted.
- `load_err`  out  1  memory filled before `ld_last` arrived.

## Operation
- FSM states: LOAD, RUN, DONE.
- Reset:
  - Enters LOAD.
  - Clears the write pointer, `load_count`, `load_err`, `final_stat`, `cpu_run` and `done`.
  - Does not clear memory contents.
  - A reset asserted mid-load or mid-run restarts loading at address 0.
- LOAD:
  - `ld_ready`=1.
  - Accept means `ld_valid`&`ld_ready` at the edge.
  - On accept: write `ld_data` to mem[wptr], increment wptr, increment `load_count`.
  - Accept with `ld_last`=1 → RUN.
  - Accept at wptr=`MEM_BYTES`-1 with `ld_last`=0 → set `load_err`, go to DONE with `final_stat`=0. The processor never runs.
  - Accept at wptr=`MEM_BYTES`-1 with `ld_last`=1 is a legal full load → RUN.
- RUN:
  - `ld_ready`=0, `cpu_run`=1.
  - Loader inputs are ignored.
  - `stat`≠0 sampled at the edge → latch `final_stat`=`stat`, go to DONE.
- DONE:
  - `cpu_run`=0, `done`=1, `ld_ready`=0.
  - All outputs hold until `rst`.
- Fetch port:
  - Combinational and asynchronous from memory, available in every state.
  - Any byte whose address ≥ `MEM_BYTES` reads as 0x00.
  - `imem_error` is pure combinational from `f_PC`.
- Writes land at the clock edge. A same-cycle fetch of the address being written returns the old byte.

## Timing
- `ld_ready`, `cpu_run`, `done`, `load_err`, `final_stat` and `load_count` are registered and driven from state.
- Reset values: `ld_ready`=1 (LOAD), `cpu_run`=0, `done`=0, `load_err`=0, `final_stat`=0, `load_count`=0.
- Last byte accepted at edge N:
  - `ld_ready` falls and `cpu_run` rises in the cycle after edge N.
  - Memory write is visible to fetch after edge N.
- Non-AOK `stat` sampled at edge M: `cpu_run` falls and `done` rises after edge M. The value of `stat` at edge M is the one held in `final_stat`.
- Throughput: one byte per cycle while `ld_valid` is held high.
- `ld_valid` may drop between bytes with no penalty.

## Test plan
- Load `30 F2 05 00 00 00 00 00 00 00 00`, with `ld_last` on the 11th byte:
  - `load_count`=11.
  - `cpu_run`=1 one cycle after the last accept.
  - `f_PC`=0 → `f_instr`[15:0]=0xF230, `imem_error`=0.
- Reset mid-load after 4 bytes, then load 2 bytes with `ld_last` on the second → `load_count`=2, state RUN.
- In RUN, drive `stat`=1 (HLT) for one cycle, then 0:
  - `done`=1, `cpu_run`=0, `final_stat`=1, all held.
  - `ld_valid` pulses now → no accept, `load_count` unchanged.
- Stream `MEM_BYTES` bytes with no `ld_last` → `load_err`=1, `done`=1, `cpu_run` never asserts, `load_count`=1024.
- `f_PC`=1014 → `imem_error`=0. `f_PC`=1015 → `imem_error`=1 and `f_instr`[79:72]=0x00.
- `f_PC`=0xFFFF_FFFF_FFFF_FFFF → `imem_error`=1.
